peak_detect_4bit: RTL and testbench
===================================

# peak_detect_4bit

Windowed peak detector for 4-bit two's-complement samples, placed directly upstream of the result consumer and built around the team's 4-bit greater/equal compare stage. Each accepted sample is compared against the registered running maximum. After `WINDOW` samples the block reports the peak value, the index of the peak's first occurrence, and how many samples tied it. Input and output both use valid/ready handshakes.

## Interface
- `WINDOW`, default 8: samples per window; legal range 2..2^`CNT_W`.
- `CNT_W`, default 4: width of the index counter.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts a sample this cycle.
- `in_data` in 4: sample, signed two's complement.
- `clear` in 1: synchronous abort of the current window.
- `out_valid` out 1: result registers hold a completed window.
- `out_ready` in 1: consumer takes the result.
- `out_max` out 4: window peak.
- `out_max_idx` out `CNT_W`: 0-based index of the first sample equal to the peak.
- `out_tie_cnt` out `CNT_W`+1: number of samples equal to the peak, first occurrence included.
- `busy` out 1: a window is partially filled.

## Operation
- Accept condition: `in_valid && in_ready`.
- `in_ready` = (state != DONE), driven combinationally from state only.
- States and transitions:
  - **IDLE**: first accepted sample loads max unconditionally; idx=0, tie=1, count=1; go to TRACK. If `WINDOW` were 1 the block would go straight to DONE, but 1 is illegal.
  - **TRACK**: each accepted sample at position `count`:
    - sample > max: load max, idx=`count`, tie=1.
    - sample == max: tie+1.
    - otherwise: no change.
    - Always count+1.
    - On the accept with `count` == `WINDOW`-1: copy the final max/idx/tie into the output registers, assert `out_valid`, go to DONE.
  - **DONE**: holds outputs. On `out_ready`: deassert `out_valid`, go to IDLE.
- Comparison is signed: a > b is computed as the unsigned magnitude compare of all 4 bits, XORed with a[3]^b[3], consistent with the compare stage. Equality is bitwise.
- `busy` = (state == TRACK).
- `clear` forces IDLE from any state:
  - zeroes count/max/idx/tie;
  - drops `out_valid`;
  - any sample accepted that same cycle is discarded;
  - takes priority over a simultaneous input accept and a simultaneous output handshake.
- Output registers change only on the transition into DONE, on `clear`, or on reset. They stay stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` low, takes effect immediately, no clock needed):
  - state=IDLE; `out_valid`=0; `out_max`=0; `out_max_idx`=0; `out_tie_cnt`=0; `busy`=0.
  - `in_ready`=1.
- Result latency: `out_valid` rises on the edge that accepts the `WINDOW`-th sample, i.e. visible the following cycle.
- Sustained throughput: one sample per cycle inside a window. Each window costs at least 1 DONE cycle plus 1 IDLE re-entry with `in_ready`=1 (no bubble if `out_ready` is already high).
- Back-to-back windows: with `out_ready` tied high, window N+1 may start its first accept the cycle after DONE.
- Reset mid-window discards all partial state; no result is produced.

## Configuration
- `PEAK_DETECT_UNSIGNED_EN`:
  - Defined: comparison is unsigned (no sign-bit XOR correction); `in_data` and `out_max` are treated as 0..15.
  - Undefined (default): signed two's-complement comparison as described above.
  - Interface and timing are identical either way.

## Test plan
All scenarios use `WINDOW`=4, `CNT_W`=2.
- Basic window: samples 3, -2, 5, 1 with `out_ready`=1 → `out_max`=5, idx=2, tie=1, `out_valid` high for exactly 1 cycle, one cycle after the 4th accept.
- Signed vs unsigned: samples 4'h8, 4'h7, 4'h2, 4'h1:
  - default build → max=4'h7, idx=1, tie=1;
  - with `PEAK_DETECT_UNSIGNED_EN` → max=4'h8, idx=0, tie=1.
- Ties: samples -1, -8, -3, -1 → max=4'hF, idx=0, tie=2. Samples 4'h8 ×4 → max=4'h8, idx=0, tie=4.
- Backpressure: hold `out_ready`=0 for 5 cycles after completion → outputs unchanged; `in_ready`=0; extra `in_valid` pulses ignored. Raise `out_ready` → `out_valid` drops next cycle; the next window is accepted correctly.
- Clear: assert `clear` after 2 samples (9 is not representable; use 6, 2) → `busy`=0 next cycle. The next 4 samples 1, 2, 3, 0 → max=3, idx=2, tie=1.
- Async reset mid-window, and again during DONE → all outputs 0 without a clock edge; `in_ready`=1. After release, a fresh window produces correct results.

Source files
------------

// File: rtl/peak_detect_4bit.sv
// Windowed peak detector: reports max, first-peak index and tie count every WINDOW samples.
// Latency: out_valid is visible the cycle after the WINDOW-th accept; in_ready drops while a result waits.
// Optional macro PEAK_DETECT_UNSIGNED_EN selects an unsigned compare instead of signed.
module peak_detect_4bit #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_max,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W:0]   out_tie_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [3:0]       cur_max;
  logic [CNT_W-1:0] cur_idx;
  logic [CNT_W:0]   cur_tie;

  logic             accept;
  logic             sample_gt;
  logic             sample_eq;
  logic             done_load;
  logic [3:0]       nxt_max;
  logic [CNT_W-1:0] nxt_idx;
  logic [CNT_W:0]   nxt_tie;

  // Magnitude compare of all 4 bits; the sign-bit XOR turns it into a signed compare.
  function automatic logic greater(input logic [3:0] a, input logic [3:0] b);
`ifdef PEAK_DETECT_UNSIGNED_EN
    return (a > b);
`else
    return (a > b) ^ (a[3] ^ b[3]);
`endif
  endfunction

  assign in_ready  = (state != DONE);
  assign busy      = (state == TRACK);
  assign accept    = in_valid && in_ready;
  assign sample_gt = greater(in_data, cur_max);
  assign sample_eq = (in_data == cur_max);

  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
    nxt_tie = cur_tie;
    if (sample_gt) begin
      nxt_max = in_data;
      nxt_idx = count;
      nxt_tie = (CNT_W+1)'(1);
    end else if (sample_eq) begin
      nxt_tie = cur_tie + (CNT_W+1)'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    done_load = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (accept) state_nxt = TRACK;
        TRACK: begin
          if (accept && (count == LAST_IDX)) begin
            state_nxt = DONE;
            done_load = 1'b1;
          end
        end
        DONE:  if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      cur_max     <= '0;
      cur_idx     <= '0;
      cur_tie     <= '0;
      out_valid   <= 1'b0;
      out_max     <= '0;
      out_max_idx <= '0;
      out_tie_cnt <= '0;
    end else if (clear) begin
      count       <= '0;
      cur_max     <= '0;
      cur_idx     <= '0;
      cur_tie     <= '0;
      out_valid   <= 1'b0;
      out_max     <= '0;
      out_max_idx <= '0;
      out_tie_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_max <= in_data;
            cur_idx <= '0;
            cur_tie <= (CNT_W+1)'(1);
            count   <= CNT_W'(1);
          end
        end
        TRACK: begin
          if (accept) begin
            cur_max <= nxt_max;
            cur_idx <= nxt_idx;
            cur_tie <= nxt_tie;
            count   <= done_load ? '0 : count + CNT_W'(1);
          end
          // Publish the running values including this final sample.
          if (done_load) begin
            out_valid   <= 1'b1;
            out_max     <= nxt_max;
            out_max_idx <= nxt_idx;
            out_tie_cnt <= nxt_tie;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_detect_4bit.sv
// Directed bench for peak_detect_4bit with WINDOW=4, CNT_W=2.
module tb_peak_detect_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [1:0] out_max_idx;
  logic [2:0] out_tie_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  peak_detect_4bit #(.WINDOW(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_max_idx(out_max_idx),
    .out_tie_cnt(out_tie_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_window(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic chk_result(input string tag, input logic [3:0] m,
                            input logic [1:0] idx, input logic [2:0] tie);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_max"}, {4'd0, out_max}, {4'd0, m});
    chk({tag, "_idx"}, {6'd0, out_max_idx}, {6'd0, idx});
    chk({tag, "_tie"}, {5'd0, out_tie_cnt}, {5'd0, tie});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd0);
    chk({tag, "_max"}, {4'd0, out_max}, 8'd0);
    chk({tag, "_idx"}, {6'd0, out_max_idx}, 8'd0);
    chk({tag, "_tie"}, {5'd0, out_tie_cnt}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    clear     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Basic window 3,-2,5,1
    send(4'h3);
    chk("basic_busy", {7'd0, busy}, 8'd1);
    send(4'hE);
    send(4'h5);
    send(4'h1);
    chk_result("basic", 4'h5, 2'd2, 3'd1);
    chk("basic_in_ready_done", {7'd0, in_ready}, 8'd0);
    chk("basic_busy_done", {7'd0, busy}, 8'd0);
    step();
    chk("basic_valid_one_cycle", {7'd0, out_valid}, 8'd0);
    chk("basic_in_ready_idle", {7'd0, in_ready}, 8'd1);

    // Signed vs unsigned ordering of 4'h8 against 4'h7
    run_window(4'h8, 4'h7, 4'h2, 4'h1);
`ifdef PEAK_DETECT_UNSIGNED_EN
    chk_result("sign", 4'h8, 2'd0, 3'd1);
`else
    chk_result("sign", 4'h7, 2'd1, 3'd1);
`endif
    step();

    // Ties: -1,-8,-3,-1 then 8 x4
    run_window(4'hF, 4'h8, 4'hD, 4'hF);
    chk_result("tie2", 4'hF, 2'd0, 3'd2);
    step();
    run_window(4'h8, 4'h8, 4'h8, 4'h8);
    chk_result("tie4", 4'h8, 2'd0, 3'd4);
    step();

    // Backpressure: result held with out_ready low, extra inputs ignored
    out_ready = 1'b0;
    run_window(4'h1, 4'h2, 4'h3, 4'h4);
    chk_result("bp", 4'h4, 2'd3, 3'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'h7;
      step();
      chk("bp_hold_valid", {7'd0, out_valid}, 8'd1);
      chk("bp_hold_max", {4'd0, out_max}, 8'h04);
      chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
    end
    in_valid = 1'b0;
    chk_result("bp_hold", 4'h4, 2'd3, 3'd1);
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {7'd0, out_valid}, 8'd0);
    run_window(4'h2, 4'h2, 4'h0, 4'h1);
    chk_result("bp_next", 4'h2, 2'd0, 3'd2);
    step();

    // Clear after two samples, with a sample offered in the clear cycle
    send(4'h6);
    send(4'h2);
    in_valid = 1'b1;
    in_data  = 4'h7;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_busy", {7'd0, busy}, 8'd0);
    chk("clear_valid", {7'd0, out_valid}, 8'd0);
    chk("clear_in_ready", {7'd0, in_ready}, 8'd1);
    run_window(4'h1, 4'h2, 4'h3, 4'h0);
    chk_result("clear_next", 4'h3, 2'd2, 3'd1);
    step();

    // Async reset mid-window
    send(4'h7);
    send(4'h6);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    #2 rst_n = 1'b1;
    step();
    run_window(4'h5, 4'h5, 4'hF, 4'h4);
    chk_result("rst_mid_next", 4'h5, 2'd0, 3'd2);

    // Async reset while a result waits in DONE
    out_ready = 1'b0;
    step();
    chk("rst_done_pre_valid", {7'd0, out_valid}, 8'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_done");
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    run_window(4'h0, 4'hC, 4'h6, 4'h6);
    chk_result("rst_done_next", 4'h6, 2'd2, 3'd2);
    step();
    chk("final_valid_drop", {7'd0, out_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
